drop_time_sqrt: RTL and testbench
=================================

Name: drop_time_sqrt

Overview:
- Sequential unsigned square-root stage directly downstream of the combinational height estimator.
- Consumes the 8-bit averaged height and produces the fixed-point drop time t_act = sqrt(height), with FRAC_BITS fractional bits.
- Computes by a digit-by-digit restoring algorithm, one result bit per clock, to save area.
- Sits between the height estimator and the display/drop-control logic, with valid/ready handshakes on both sides.

Parameters:
- FRAC_BITS, 8, number of fractional bits in t_act; legal range 0..12, so that 4+FRAC_BITS ≤ 16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- height  input  8  unsigned height from the estimator; sampled only on an accepted transfer.
- in_valid  input  1  height is valid.
- in_ready  output  1  block can accept a new height.
- t_act  output  16  floor(sqrt(height)·2^FRAC_BITS), zero-extended to 16 bits.
- out_valid  output  1  t_act is valid.
- out_ready  input  1  consumer accepts t_act.

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; t_act=0; all internal registers 0.
- Radicand: R = height << (2·FRAC_BITS), width 8+2·FRAC_BITS.
- Root: 4+FRAC_BITS bits.
- Remainder register: 6+FRAC_BITS bits, with no overflow allowed.

State IDLE:
- in_ready=1.
- On in_valid&&in_ready: latch R, clear root/remainder, load iteration counter with 4+FRAC_BITS, go to CALC.

State CALC:
- in_ready=0.
- Each cycle: shift the top 2 radicand bits into the remainder; trial = (root<<2)|1.
- If remainder ≥ trial: remainder -= trial and root=(root<<1)|1; else root<<=1.
- Decrement the counter; at the last iteration go to DONE (or ROUND when ROUND_EN is defined).

State DONE:
- out_valid=1; t_act=root, zero-extended.
- t_act and out_valid are held stable while out_ready=0.
- On out_ready: out_valid drops next cycle, go to IDLE.
- No new input is accepted in DONE (no overlap).

Latency and throughput:
- Accept at edge N → out_valid high after edge N+4+FRAC_BITS (12 cycles at default).
- Throughput is one result per 13+ cycles.

Boundary cases:
- height=0: runs the full iteration count, result 0.
- height=255: max result, never exceeds 4+FRAC_BITS bits.
- in_valid asserted during CALC/DONE: ignored, because in_ready=0; upstream must hold.
- out_ready high before out_valid: no effect.
- rst_n low mid-CALC or in DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse occurs.

Optional Feature:
- Macro: DROP_TIME_ROUND_EN.
- Defined:
  - After CALC, add one ROUND state (1 cycle).
  - If final remainder > root then root += 1 (round to nearest; ties cannot occur).
  - Latency becomes 5+FRAC_BITS.
- Undefined:
  - No ROUND state; result truncated (floor).
  - Latency 4+FRAC_BITS.

Test Plan:
- Reset then idle: rst_n low 3 cycles → in_ready=1, out_valid=0, t_act=0; hold idle 20 cycles → no change.
- Exact roots, FRAC_BITS=8:
  - height=0 → t_act=0x0000.
  - height=1 → 0x0100.
  - height=4 → 0x0200.
  - height=100 → 0x0A00.
  - Each out_valid rises exactly 12 cycles after accept.
- Irrational roots:
  - height=2 → 0x016A (362) in both builds, since remainder 28 ≤ 362.
  - height=255 → 0x0FF7 (4087) truncated; 0x0FF8 with DROP_TIME_ROUND_EN, latency 13.
- Backpressure:
  - height=9, out_ready low for 5 cycles after out_valid → t_act=0x0300 stable, in_ready=0.
  - New in_valid with height=16 is held by upstream and accepted only after out_ready handshake → 0x0400.
- Reset mid-operation: accept height=200, pull rst_n low at cycle 5 of CALC → out_valid never asserts; after release, height=49 → 0x0700.
- Parameter sweep: FRAC_BITS=0 with height=255 → t_act=15, latency 4; FRAC_BITS=12 with height=1 → 0x1000, latency 16.

Source files
------------

// File: rtl/drop_time_sqrt_if.sv
// rtl/drop_time_sqrt_if.sv - handshake bundle between height estimator, sqrt stage and consumer
//
// Ports carried:
//   height    [7:0]  unsigned height from the estimator
//   in_valid         height is valid
//   in_ready         sqrt stage can accept a new height
//   t_act     [15:0] fixed-point drop time, zero-extended
//   out_valid        t_act is valid
//   out_ready        consumer accepts t_act
// Modports: slave = sqrt stage view, master = upstream/downstream (bench) view.
interface drop_time_sqrt_if;
    logic [7:0]  height;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] t_act;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  height, in_valid, out_ready,
        output in_ready, t_act, out_valid
    );

    modport master (
        output height, in_valid, out_ready,
        input  in_ready, t_act, out_valid
    );
endinterface

// File: rtl/drop_time_sqrt.sv
// rtl/drop_time_sqrt.sv - sequential restoring square root, t_act = sqrt(height) in fixed point
//
// Computes t_act = floor(sqrt(height) * 2^FRAC_BITS), one root bit per clock.
// Optional macro DROP_TIME_ROUND_EN adds one ROUND cycle that rounds to nearest.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    drop_time_sqrt_if.slave: height/in_valid/in_ready in,
//          t_act/out_valid/out_ready out
// Parameter:
//   FRAC_BITS  fractional bits of t_act, 0..12
module drop_time_sqrt #(
    parameter int FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    drop_time_sqrt_if.slave   bus
);
    localparam int RW = 4 + FRAC_BITS;      // root width
    localparam int MW = 6 + FRAC_BITS;      // remainder width
    localparam int DW = 8 + 2 * FRAC_BITS;  // radicand width

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
`ifdef DROP_TIME_ROUND_EN
    localparam logic [1:0] S_ROUND = 2'd3;
`endif

    logic [1:0]    state;
    logic [DW-1:0] rad;
    logic [RW-1:0] root;
    logic [MW-1:0] rem;
    logic [4:0]    cnt;

    // One restoring step: bring in the next radicand digit pair and
    // try subtracting (root<<2)|1.
    logic [MW+1:0] rem_sh;
    logic [MW+1:0] trial;
    logic [MW-1:0] rem_next;
    logic [RW-1:0] root_next;

    always_comb begin
        rem_sh    = {rem, rad[DW-1 -: 2]};
        trial     = {2'b00, root, 2'b01};
        rem_next  = rem_sh[MW-1:0];
        root_next = {root[RW-2:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_next  = MW'(rem_sh - trial);
            root_next = {root[RW-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rad   <= '0;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        rad   <= DW'(bus.height) << (2 * FRAC_BITS);
                        root  <= '0;
                        rem   <= '0;
                        cnt   <= 5'(RW);
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    rad  <= rad << 2;
                    rem  <= rem_next;
                    root <= root_next;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
`ifdef DROP_TIME_ROUND_EN
                        state <= S_ROUND;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef DROP_TIME_ROUND_EN
                S_ROUND: begin
                    // rem > root means the true root's next bit is 1, i.e. the
                    // fraction is above one half. At FRAC_BITS=0 a near-16 root
                    // would need a fifth bit, so the result saturates instead.
                    if ((MW'(root) < rem) && !(&root)) begin
                        root <= root + RW'(1);
                    end
                    state <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.t_act     = 16'(root);

endmodule

// File: tb/tb_drop_time_sqrt.sv
// tb/tb_drop_time_sqrt.sv - directed table-driven bench for drop_time_sqrt
module tb_drop_time_sqrt;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    drop_time_sqrt_if bus8 ();
    drop_time_sqrt_if bus0 ();
    drop_time_sqrt_if bus12 ();

    drop_time_sqrt #(.FRAC_BITS(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    drop_time_sqrt #(.FRAC_BITS(0))  dut0  (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    drop_time_sqrt #(.FRAC_BITS(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12.slave));

`ifdef DROP_TIME_ROUND_EN
    localparam int          RX   = 1;
    localparam logic [15:0] E255 = 16'h0FF8;
`else
    localparam int          RX   = 0;
    localparam logic [15:0] E255 = 16'h0FF7;
`endif

    typedef struct {
        logic [7:0]  h;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[9];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic [7:0] h, input logic v);
        case (sel)
            0:  begin bus0.height = h;  bus0.in_valid = v;  end
            12: begin bus12.height = h; bus12.in_valid = v; end
            default: begin bus8.height = h; bus8.in_valid = v; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            0:  bus0.out_ready = v;
            12: bus12.out_ready = v;
            default: bus8.out_ready = v;
        endcase
    endtask

    function automatic logic get_valid(input int sel);
        case (sel)
            0:  return bus0.out_valid;
            12: return bus12.out_valid;
            default: return bus8.out_valid;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:  return bus0.in_ready;
            12: return bus12.in_ready;
            default: return bus8.in_ready;
        endcase
    endfunction

    function automatic logic [15:0] get_t(input int sel);
        case (sel)
            0:  return bus0.t_act;
            12: return bus12.t_act;
            default: return bus8.t_act;
        endcase
    endfunction

    // Waits for out_valid after an accept; lat counts edges after the accept edge.
    task automatic wait_valid(input int sel, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (get_valid(sel)) break;
        end
        if (!get_valid(sel)) begin
            check("out_valid_timeout", 0, 1);
        end
    endtask

    task automatic handshake(input int sel);
        set_ordy(sel, 1'b1);
        @(posedge clk); #1;
        set_ordy(sel, 1'b0);
        check("valid_drop_after_ready", 32'(get_valid(sel)), 0);
    endtask

    task automatic run(input int sel, input logic [7:0] h, output logic [15:0] res, output int lat);
        @(negedge clk);
        set_in(sel, h, 1'b1);
        check("in_ready_before_accept", 32'(get_ready(sel)), 1);
        @(posedge clk); #1;
        set_in(sel, 8'd0, 1'b0);
        wait_valid(sel, lat);
        res = get_t(sel);
        handshake(sel);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] res;
        int lat;
        bit seen;

        vt[0] = '{8'd0,   16'h0000};
        vt[1] = '{8'd1,   16'h0100};
        vt[2] = '{8'd4,   16'h0200};
        vt[3] = '{8'd100, 16'h0A00};
        vt[4] = '{8'd2,   16'h016A};
        vt[5] = '{8'd255, E255};
        vt[6] = '{8'd64,  16'h0800};
        vt[7] = '{8'd200, 16'h0E24};
        vt[8] = '{8'd49,  16'h0700};

        set_in(0, 8'd0, 1'b0); set_in(8, 8'd0, 1'b0); set_in(12, 8'd0, 1'b0);
        set_ordy(0, 1'b0); set_ordy(8, 1'b0); set_ordy(12, 1'b0);

        // Reset, then idle for 20 cycles with no change.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus8.in_ready), 1);
        check("rst_out_valid", 32'(bus8.out_valid), 0);
        check("rst_t_act", 32'(bus8.t_act), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_in_ready", 32'(bus8.in_ready), 1);
            check("idle_out_valid", 32'(bus8.out_valid), 0);
            check("idle_t_act", 32'(bus8.t_act), 0);
        end

        // Table-driven results and latency at FRAC_BITS=8.
        for (int i = 0; i < 9; i++) begin
            run(8, vt[i].h, res, lat);
            check($sformatf("t_act_h%0d", vt[i].h), 32'(res), 32'(vt[i].exp));
            check($sformatf("latency_h%0d", vt[i].h), 32'(lat), 32'(12 + RX));
        end

        // Backpressure: result held, new input held upstream until handshake.
        @(negedge clk);
        set_in(8, 8'd9, 1'b1);
        set_ordy(8, 1'b0);
        @(posedge clk); #1;
        set_in(8, 8'd16, 1'b1);
        check("calc_in_ready", 32'(bus8.in_ready), 0);
        wait_valid(8, lat);
        check("bp_latency", 32'(lat), 32'(12 + RX));
        for (int i = 0; i < 5; i++) begin
            check("bp_t_act", 32'(bus8.t_act), 32'h0300);
            check("bp_out_valid", 32'(bus8.out_valid), 1);
            check("bp_in_ready", 32'(bus8.in_ready), 0);
            @(posedge clk); #1;
        end
        check("bp_t_act_last", 32'(bus8.t_act), 32'h0300);
        handshake(8);
        check("bp_in_ready_after", 32'(bus8.in_ready), 1);
        @(posedge clk); #1;
        set_in(8, 8'd0, 1'b0);
        check("bp_second_accepted", 32'(bus8.in_ready), 0);
        wait_valid(8, lat);
        check("bp_second_t_act", 32'(bus8.t_act), 32'h0400);
        check("bp_second_latency", 32'(lat), 32'(12 + RX));
        handshake(8);

        // Reset in the middle of CALC discards the result.
        @(negedge clk);
        set_in(8, 8'd200, 1'b1);
        @(posedge clk); #1;
        set_in(8, 8'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("mid_calc_busy", 32'(bus8.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus8.out_valid), 0);
        check("mid_rst_in_ready", 32'(bus8.in_ready), 1);
        check("mid_rst_t_act", 32'(bus8.t_act), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus8.out_valid) seen = 1'b1;
        end
        check("mid_rst_no_valid", 32'(seen), 0);
        run(8, 8'd49, res, lat);
        check("after_rst_t_act", 32'(res), 32'h0700);

        // Parameter sweep instances.
        run(0, 8'd255, res, lat);
        check("fb0_t_act", 32'(res), 32'd15);
        check("fb0_latency", 32'(lat), 32'(4 + RX));
        run(12, 8'd1, res, lat);
        check("fb12_t_act", 32'(res), 32'h1000);
        check("fb12_latency", 32'(lat), 32'(16 + RX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
